// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding RV32 load/store initiator for a byte-lane memory.
// Accepts a request over valid/ready and drives the memory with active-low
// per-lane write strobes. It returns a response with extended load data, or
// with an error for an illegal size code.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_we, req_funct3         store flag, RV32 size/sign code
//   req_addr, req_wdata        byte address, store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_err       extended load data, illegal-request flag
//   mem_addr, mem_w_bar        memory address, per-lane write enable (active-low)
//   mem_data_w, mem_data_r     per-lane write bytes, per-lane read bytes (1-cycle latency)
module lsu_mem_port #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [2:0]                    req_funct3,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [31:0]                   req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [31:0]                   resp_rdata,
    output logic                          resp_err,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH_BYTES-1:0]   mem_w_bar,
    output logic [8*DATA_WIDTH_BYTES-1:0] mem_data_w,
    input  logic [8*DATA_WIDTH_BYTES-1:0] mem_data_r
);

    localparam int unsigned DW = 8 * DATA_WIDTH_BYTES;
    localparam int unsigned NB = DATA_WIDTH_BYTES;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [NB-1:0]   mem_w_bar_q, mem_w_bar_d;
    logic [DW-1:0]   mem_data_w_q, mem_data_w_d;

    // Legal codes: 0/1/2 for loads and stores, 4/5 (unsigned) for loads only.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3[1:0] != 2'd3) && !(f3[2] && f3[1]);
        if (we && f3[2]) ok = 1'b0;
        return ok;
    endfunction

    // Lanes touched by an access of the given size, lane 0 first.
    function automatic logic [NB-1:0] lane_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return NB'(1);
            2'd1:    return NB'(3);
            default: return '1;
        endcase
    endfunction

    // Little-endian assembly with sign (funct3[2]=0) or zero (funct3[2]=1) fill.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [DW-1:0] d);
        logic s;
        case (f3[1:0])
            2'd0: begin
                s = ~f3[2] & d[7];
                return {{24{s}}, d[7:0]};
            end
            2'd1: begin
                s = ~f3[2] & d[15];
                return {{16{s}}, d[15:0]};
            end
            default: return d[31:0];
        endcase
    endfunction

    // Next-state and next-output logic; memory outputs for ISSUE are prepared on entry.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_w_bar_d  = '1;
        mem_data_w_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    if (is_legal(req_we, req_funct3)) begin
                        state_d    = ISSUE;
                        mem_addr_d = req_addr;
                        if (req_we) begin
                            mem_w_bar_d  = ~lane_mask(req_funct3);
                            mem_data_w_d = DW'(req_wdata);
                        end
                    end else begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d      = RESP;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d      = RESP;
                resp_rdata_d = extend(funct3_q, mem_data_r);
                resp_err_d   = 1'b0;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_w_bar_q  <= '1;
            mem_data_w_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            req_ready_q  <= (state_d == IDLE);
            resp_valid_q <= (state_d == RESP);
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_bar_q  <= mem_w_bar_d;
            mem_data_w_q <= mem_data_w_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_w_bar  = mem_w_bar_q;
    assign mem_data_w = mem_data_w_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed test-plan steps plus random
// requests, checked against a byte-array reference of memory contents.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_w_bar;
    logic [31:0] mem_data_w;
    logic [31:0] mem_data_r;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [7:0] mem     [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    always #5 clk = ~clk;

    lsu_mem_port #(.ADDR_WIDTH(32), .DATA_WIDTH_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_w_bar  (mem_w_bar),
        .mem_data_w (mem_data_w),
        .mem_data_r (mem_data_r)
    );

    // Registered byte-lane memory: lane i is byte mem_addr+i, read data one cycle later.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!mem_w_bar[i]) mem[8'(mem_addr + 32'(i))] <= mem_data_w[8*i +: 8];
            mem_data_r[8*i +: 8] <= mem[8'(mem_addr + 32'(i))];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total = checks_total + 1;
        assert (obs === exp) checks_passed = checks_passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit ref_legal(input bit we, input int f3);
        if (f3 == 3 || f3 >= 6) return 1'b0;
        if (we && f3 >= 4) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ref_bytes(input int f3);
        return 1 << (f3 % 4);
    endfunction

    // Load value from the reference memory as an integer, then wrap to 32 bits.
    function automatic logic [31:0] ref_load(input int f3, input int a);
        longint v;
        int n;
        n = ref_bytes(f3);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % 256]) << (8 * i);
        if (f3 < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    // One full request/response, entered and left at a negedge with resp_ready=1.
    task automatic do_req(input bit we, input int f3, input int a, input logic [31:0] wd,
                          input int stall, input string tag);
        bit          ok;
        int          n, lat, k, writes;
        logic [31:0] exp_rd;
        logic [3:0]  exp_bar;
        ok = ref_legal(we, f3);
        n  = ref_bytes(f3);
        if (!ok) begin lat = 1; exp_rd = 32'h0; end
        else if (we) begin lat = 2; exp_rd = 32'h0; end
        else begin lat = 3; exp_rd = ref_load(f3, a); end
        exp_bar = (ok && we) ? 4'(~((1 << n) - 1)) : 4'hF;

        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);

        resp_ready = (stall == 0);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = 3'(f3);
        req_addr   = 32'(a);
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        writes = 0;
        k = 1;
        while (resp_valid !== 1'b1 && k < 8) begin
            if (k == 1) chk({tag, " mem_addr"}, mem_addr, 32'(a));
            if (mem_w_bar !== 4'hF) begin
                writes++;
                chk({tag, " w_bar"}, 32'(mem_w_bar), 32'(exp_bar));
                chk({tag, " data_w"}, mem_data_w, wd);
                chk({tag, " write cycle"}, 32'(k), 32'd1);
            end
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " err"}, 32'(resp_err), 32'(!ok));
        chk({tag, " w_bar idle"}, 32'(mem_w_bar), 32'hF);
        chk({tag, " data_w idle"}, mem_data_w, 32'h0);
        chk({tag, " writes"}, 32'(writes), 32'(ok && we));

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, " stall valid"}, 32'(resp_valid), 32'd1);
            chk({tag, " stall rdata"}, resp_rdata, exp_rd);
            chk({tag, " stall err"}, 32'(resp_err), 32'(!ok));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " resp done"}, 32'(resp_valid), 32'd0);
        chk({tag, " ready back"}, 32'(req_ready), 32'd1);

        if (ok && we)
            for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = wd[8*i +: 8];
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset w_bar", 32'(mem_w_bar), 32'hF);
        chk("reset data_w", mem_data_w, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1, 2, 'h10, 32'hDEADBEEF, 0, "SW 10");
        do_req(0, 2, 'h10, 32'h0, 0, "LW 10");
        do_req(1, 2, 'h20, 32'h000080FF, 0, "SW 20");
        do_req(0, 0, 'h20, 32'h0, 0, "LB 20");
        do_req(0, 4, 'h20, 32'h0, 0, "LBU 20");
        do_req(0, 1, 'h20, 32'h0, 0, "LH 20");
        do_req(0, 5, 'h20, 32'h0, 0, "LHU 20");
        do_req(1, 2, 'h30, 32'hA5A5A5A5, 0, "SW 30");
        do_req(1, 0, 'h30, 32'h12345678, 0, "SB 30");
        do_req(0, 2, 'h30, 32'h0, 0, "LW 30 after SB");
        do_req(1, 1, 'h30, 32'h12345678, 0, "SH 30");
        do_req(0, 2, 'h30, 32'h0, 0, "LW 30 after SH");
        do_req(1, 2, 'h21, 32'hAABBCCDD, 0, "SW 21");
        do_req(0, 2, 'h21, 32'h0, 0, "LW 21");
        do_req(0, 4, 'h20, 32'h0, 0, "LBU 20 neighbour");
        do_req(0, 3, 'h10, 32'h0, 0, "illegal f3=3");
        do_req(1, 4, 'h10, 32'h11223344, 0, "illegal SBU");
        do_req(1, 7, 'h10, 32'h11223344, 0, "illegal f3=7 store");
        do_req(0, 2, 'h10, 32'h0, 0, "LW 10 after illegal");
        do_req(0, 2, 'h10, 32'h0, 5, "LW stall");
        do_req(1, 0, 'h12, 32'h0000007E, 3, "SB stall");

        // Store aborted by reset on the edge that would have entered ISSUE.
        do_req(1, 2, 'h40, 32'hCAFEF00D, 0, "SW 40");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h40;
        req_wdata  = 32'h11111111;
        rst        = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst store resp_valid", 32'(resp_valid), 32'd0);
        chk("rst store req_ready", 32'(req_ready), 32'd0);
        chk("rst store w_bar", 32'(mem_w_bar), 32'hF);
        rst = 1'b0;
        @(negedge clk);
        chk("rst store w_bar after", 32'(mem_w_bar), 32'hF);
        do_req(0, 2, 'h40, 32'h0, 0, "LW 40 after reset");

        // Load aborted by reset while in CAPTURE.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst load resp_valid", 32'(resp_valid), 32'd0);
        chk("rst load w_bar", 32'(mem_w_bar), 32'hF);
        chk("rst load rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        k = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) k++;
        end
        chk("rst load no response", 32'(k), 32'd0);

        for (int r = 0; r < 40; r++) begin
            int st;
            st = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
            do_req(1'($urandom), int'($urandom % 8), int'($urandom % 240), $urandom, st, "random");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
